// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared state/type encodings and instruction field helpers
package cu_pkg;

    typedef enum logic [5:0] {
        S_IDLE       = 6'b000001,
        S_FETCH      = 6'b000010,
        S_DECODE     = 6'b000100,
        S_EXECUTE    = 6'b001000,
        S_MEM_ACCESS = 6'b010000,
        S_WRITE_BACK = 6'b100000
    } state_t;

    typedef enum logic [1:0] {
        T_NOP   = 2'b00,
        T_STD   = 2'b01,
        T_LOAD  = 2'b10,
        T_STORE = 2'b11
    } itype_t;

    localparam logic [3:0] RESET_OPCODE = 4'hF;

    // Word layout MSB->LSB: type, rd, rs1, rs2, offset, opcode[3:0]
    function automatic logic [31:0] field_slice(input logic [63:0] word, input int lsb, input int width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return 32'((word >> lsb) & mask);
    endfunction

    function automatic logic [31:0] field_rd(input logic [63:0] word, input int reg_bits, input int off_w);
        return field_slice(word, 4 + off_w + 2 * reg_bits, reg_bits);
    endfunction

    function automatic logic [31:0] field_rs1(input logic [63:0] word, input int reg_bits, input int off_w);
        return field_slice(word, 4 + off_w + reg_bits, reg_bits);
    endfunction

    function automatic logic [31:0] field_rs2(input logic [63:0] word, input int reg_bits, input int off_w);
        return field_slice(word, 4 + off_w, reg_bits);
    endfunction

    function automatic logic [31:0] field_offset(input logic [63:0] word, input int off_w);
        return field_slice(word, 4, off_w);
    endfunction

endpackage

// File: rtl/cu_multicycle_param_if.sv
// rtl/cu_multicycle_param_if.sv - instruction handshake and datapath control bundle
interface cu_multicycle_param_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int REG_BITS     = 2,
    parameter int OFFSET_WIDTH = 8,
    parameter int INSTR_WIDTH  = 2 + 3 * REG_BITS + OFFSET_WIDTH + 4
);
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [DATA_WIDTH-1:0]  result2;
    logic                   mem_ready;
    logic [DATA_WIDTH-1:0]  operand1;
    logic [DATA_WIDTH-1:0]  operand2;
    logic [DATA_WIDTH-1:0]  offset;
    logic [3:0]             opcode;
    logic                   sel1;
    logic                   sel3;
    logic                   w_r;
    logic                   retired;

    modport slave (
        input  instr, instr_valid, result2, mem_ready,
        output instr_ready, operand1, operand2, offset, opcode, sel1, sel3, w_r, retired
    );

    modport master (
        output instr, instr_valid, result2, mem_ready,
        input  instr_ready, operand1, operand2, offset, opcode, sel1, sel3, w_r, retired
    );
endinterface

// File: rtl/cu_regfile.sv
// rtl/cu_regfile.sv - register file, three async reads, one sync write, reset to index
module cu_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_BITS-1:0]   ra1,
    input  logic [REG_BITS-1:0]   ra2,
    input  logic [REG_BITS-1:0]   ra3,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    output logic [DATA_WIDTH-1:0] rd3,
    input  logic                  we,
    input  logic [REG_BITS-1:0]   wa,
    input  logic [DATA_WIDTH-1:0] wd
);
    localparam int REG_COUNT = 2 ** REG_BITS;

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= DATA_WIDTH'(i);
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];
    assign rd3 = regs[ra3];
endmodule

// File: rtl/cu_multicycle_param.sv
// rtl/cu_multicycle_param.sv - multi-cycle control unit sequencing decode/execute/memory/write-back
module cu_multicycle_param
    import cu_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int REG_BITS     = 2,
    parameter int OFFSET_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    cu_multicycle_param_if.slave   bus
);
    localparam int INSTR_WIDTH = 2 + 3 * REG_BITS + OFFSET_WIDTH + 4;

    state_t                  state, state_next;
    logic [INSTR_WIDTH-1:0]  instr_q;
    itype_t                  itype, fetch_type;
    logic                    accept, mem_op;
    logic [REG_BITS-1:0]     rd_idx, rs1_idx, rs2_idx;
    logic [OFFSET_WIDTH-1:0] off_field;
    logic [DATA_WIDTH-1:0]   r_rs1, r_rs2, r_rd;

    assign fetch_type = itype_t'(bus.instr[INSTR_WIDTH-1 -: 2]);
    assign itype      = itype_t'(instr_q[INSTR_WIDTH-1 -: 2]);
    assign accept     = (state == S_FETCH) && bus.instr_valid;
    assign mem_op     = (itype == T_LOAD) || (itype == T_STORE);

    assign rd_idx    = REG_BITS'(field_rd(64'(instr_q), REG_BITS, OFFSET_WIDTH));
    assign rs1_idx   = REG_BITS'(field_rs1(64'(instr_q), REG_BITS, OFFSET_WIDTH));
    assign rs2_idx   = REG_BITS'(field_rs2(64'(instr_q), REG_BITS, OFFSET_WIDTH));
    assign off_field = OFFSET_WIDTH'(field_offset(64'(instr_q), OFFSET_WIDTH));

    cu_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_BITS  (REG_BITS)
    ) u_regfile (
        .clk(clk),
        .rst(rst),
        .ra1(rs1_idx),
        .ra2(rs2_idx),
        .ra3(rd_idx),
        .rd1(r_rs1),
        .rd2(r_rs2),
        .rd3(r_rd),
        .we (state == S_WRITE_BACK),
        .wa (rd_idx),
        .wd (bus.result2)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:       state_next = S_FETCH;
            S_FETCH:      state_next = (bus.instr_valid && fetch_type != T_NOP) ? S_DECODE : S_FETCH;
            S_DECODE:     state_next = S_EXECUTE;
            S_EXECUTE:    state_next = mem_op ? S_MEM_ACCESS : S_WRITE_BACK;
            S_MEM_ACCESS: begin
                if (!bus.mem_ready)          state_next = S_MEM_ACCESS;
                else if (itype == T_STORE)   state_next = S_FETCH;
                else                         state_next = S_WRITE_BACK;
            end
            S_WRITE_BACK: state_next = S_FETCH;
            default:      state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q         <= '0;
            bus.instr_ready <= 1'b0;
            bus.retired     <= 1'b0;
            bus.w_r         <= 1'b0;
            bus.operand1    <= '0;
            bus.operand2    <= '0;
            bus.offset      <= '0;
            bus.opcode      <= RESET_OPCODE;
            bus.sel1        <= 1'b0;
            bus.sel3        <= 1'b0;
        end else begin
            bus.instr_ready <= (state_next == S_FETCH);
            bus.w_r         <= (state_next == S_MEM_ACCESS) && (itype == T_STORE);
            bus.retired     <= (state == S_WRITE_BACK)
                            || (state == S_MEM_ACCESS && bus.mem_ready && itype == T_STORE)
                            || (accept && fetch_type == T_NOP);
            if (accept) instr_q <= bus.instr;
            if (state == S_DECODE) begin
                bus.operand1 <= r_rs1;
                bus.operand2 <= mem_op ? r_rd : r_rs2;
                bus.offset   <= DATA_WIDTH'(off_field);
                bus.opcode   <= instr_q[3:0];
                bus.sel1     <= !mem_op;
                bus.sel3     <= mem_op;
            end
        end
    end
endmodule

// File: tb/tb_cu_multicycle_param.sv
// tb/tb_cu_multicycle_param.sv - randomized self-checking bench for cu_multicycle_param
module tb_cu_multicycle_param;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] model [4];

    always #5 clk = ~clk;

    cu_multicycle_param_if #(.DATA_WIDTH(8), .REG_BITS(2), .OFFSET_WIDTH(8)) bus ();

    cu_multicycle_param #(.DATA_WIDTH(8), .REG_BITS(2), .OFFSET_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) model[i] = 8'(i);
    endtask

    // Issues one instruction and follows it to retirement; timing comes from the latency table
    task automatic run_instr(input logic [1:0] ty, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic [7:0] off, input logic [3:0] op,
                             input int waits, input logic [7:0] res);
        int c, ret_c, wr_cnt, lat, busy_ready;
        logic [7:0] e1, e2;
        logic mem;
        c = 0;
        while (bus.instr_ready !== 1'b1 && c < 20) begin step(); c++; end
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            failures++; $display("FAIL ready_timeout: instr_ready=%b expected 1", bus.instr_ready);
        end
        mem = ty[1];
        e1 = model[rs1];
        e2 = mem ? model[rd] : model[rs2];
        bus.instr = {ty, rd, rs1, rs2, off, op};
        bus.instr_valid = 1'b1;
        bus.result2 = res;
        bus.mem_ready = 1'b0;
        step();
        bus.instr_valid = 1'b0;
        bus.instr = 20'($urandom);
        c = 1; ret_c = 0; wr_cnt = 0; busy_ready = 0;
        while (c <= 20 && ret_c == 0) begin
            if (c == 2 && ty != 2'b00) begin
                checks++;
                if (bus.operand1 !== e1) begin failures++; $display("FAIL operand1: got %0h expected %0h", bus.operand1, e1); end
                checks++;
                if (bus.operand2 !== e2) begin failures++; $display("FAIL operand2: got %0h expected %0h", bus.operand2, e2); end
                checks++;
                if (bus.offset !== off) begin failures++; $display("FAIL offset: got %0h expected %0h", bus.offset, off); end
                checks++;
                if (bus.opcode !== op) begin failures++; $display("FAIL opcode: got %0h expected %0h", bus.opcode, op); end
                checks++;
                if ({bus.sel1, bus.sel3} !== {ty == 2'b01, mem}) begin
                    failures++; $display("FAIL sel1_sel3: got %b%b expected %b%b", bus.sel1, bus.sel3, ty == 2'b01, mem);
                end
            end
            if (bus.w_r === 1'b1) wr_cnt++;
            if (bus.retired === 1'b1) begin
                ret_c = c;
                bus.instr_valid = 1'b0;
            end else begin
                if (bus.instr_ready !== 1'b0) busy_ready++;
                bus.mem_ready = (c == 3 + waits);
                bus.instr_valid = 1'($urandom_range(0, 1));
                step();
                c++;
            end
        end
        bus.mem_ready = 1'b0;
        lat = (ty == 2'b00) ? 1 : (ty == 2'b01) ? 4 : (ty == 2'b10) ? 5 + waits : 4 + waits;
        checks++;
        if (ret_c != lat) begin failures++; $display("FAIL retire_latency: got %0d expected %0d (type %0d)", ret_c, lat, ty); end
        checks++;
        if (wr_cnt != ((ty == 2'b11) ? waits + 1 : 0)) begin
            failures++; $display("FAIL w_r_cycles: got %0d expected %0d", wr_cnt, (ty == 2'b11) ? waits + 1 : 0);
        end
        checks++;
        if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL ready_at_retire: got %b expected 1", bus.instr_ready); end
        checks++;
        if (busy_ready != 0) begin failures++; $display("FAIL ready_while_busy: got %0d cycles expected 0", busy_ready); end
        if (ty == 2'b01 || ty == 2'b10) model[rd] = res;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        checks++;
        if ({bus.operand1, bus.operand2, bus.offset} !== 24'h0) begin
            failures++; $display("FAIL reset_operands: got %0h expected 0", {bus.operand1, bus.operand2, bus.offset});
        end
        checks++;
        if (bus.opcode !== 4'hF) begin failures++; $display("FAIL reset_opcode: got %0h expected f", bus.opcode); end
        checks++;
        if ({bus.sel1, bus.sel3, bus.w_r, bus.instr_ready, bus.retired} !== 5'b0) begin
            failures++; $display("FAIL reset_flags: got %b expected 00000", {bus.sel1, bus.sel3, bus.w_r, bus.instr_ready, bus.retired});
        end
        rst = 1'b1;
        model_reset();
        step();
        run_instr(2'b01, 2'd0, 2'd2, 2'd3, 8'h00, 4'h1, 0, 8'(8'h0));
    endtask

    task automatic test_std_op();
        run_instr(2'b01, 2'd1, 2'd2, 2'd3, 8'h00, 4'h0, 0, 8'd5);
        run_instr(2'b01, 2'd2, 2'd1, 2'd0, 8'h3C, 4'h7, 0, 8'($urandom));
    endtask

    task automatic test_load();
        run_instr(2'b10, 2'd0, 2'd2, 2'd1, 8'h10, 4'h0, 3, 8'($urandom));
        run_instr(2'b01, 2'd3, 2'd0, 2'd2, 8'h00, 4'h2, 0, 8'($urandom));
    endtask

    task automatic test_store();
        run_instr(2'b11, 2'd3, 2'd1, 2'd0, 8'h04, 4'h0, 0, 8'hEE);
        run_instr(2'b01, 2'd0, 2'd3, 2'd1, 8'h00, 4'h5, 0, 8'($urandom));
        run_instr(2'b11, 2'd2, 2'd0, 2'd3, 8'hFF, 4'h9, 2, 8'hAA);
    endtask

    task automatic test_nop_stream();
        int idle;
        for (int n = 0; n < 8; n++) begin
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) begin
                bus.instr_valid = 1'b0;
                step();
                checks++;
                if (bus.retired !== 1'b0) begin failures++; $display("FAIL nop_idle_retired: got %b expected 0", bus.retired); end
            end
            run_instr(2'b00, 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), 4'($urandom), 0, 8'($urandom));
        end
    endtask

    task automatic test_reset_mid_store();
        bus.instr = {2'b11, 2'd3, 2'd1, 2'd2, 8'h20, 4'h0};
        bus.instr_valid = 1'b1;
        bus.mem_ready = 1'b0;
        step();
        bus.instr_valid = 1'b0;
        step(); step();
        checks++;
        if (bus.w_r !== 1'b1) begin failures++; $display("FAIL store_w_r_before_reset: got %b expected 1", bus.w_r); end
        rst = 1'b0;
        step();
        checks++;
        if ({bus.w_r, bus.instr_ready, bus.retired} !== 3'b000) begin
            failures++; $display("FAIL midreset_flags: got %b expected 000", {bus.w_r, bus.instr_ready, bus.retired});
        end
        checks++;
        if (bus.opcode !== 4'hF) begin failures++; $display("FAIL midreset_opcode: got %0h expected f", bus.opcode); end
        rst = 1'b1;
        model_reset();
        step();
        checks++;
        if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL midreset_fetch: got %b expected 1", bus.instr_ready); end
        run_instr(2'b10, 2'd3, 2'd0, 2'd1, 8'h01, 4'h0, 1, 8'($urandom));
        run_instr(2'b01, 2'd0, 2'd2, 2'd1, 8'h00, 4'h3, 0, 8'($urandom));
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            run_instr(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
                      4'($urandom), $urandom_range(0, 3), 8'($urandom));
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.instr = '0;
        bus.instr_valid = 1'b0;
        bus.result2 = '0;
        bus.mem_ready = 1'b0;
        model_reset();
        test_reset();
        test_std_op();
        test_load();
        test_store();
        test_nop_stream();
        test_reset_mid_store();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
